// File: rtl/id_ex_operand_register.sv
// ID/EX pipeline register: captures decoded operands with EX/MEM and MEM/WB forwarding.
// Latency 1 cycle; STALL holds the stage while still refreshing operands from late producers, FLUSH inserts a bubble.
module id_ex_operand_register #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 21,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              D_VALID,
  input  logic [XLEN-1:0]   D_RA,
  input  logic [XLEN-1:0]   D_RB,
  input  logic [RIDX_W-1:0] D_RA_IDX,
  input  logic [RIDX_W-1:0] D_RB_IDX,
  input  logic [RIDX_W-1:0] D_RT_IDX,
  input  logic              D_RT_WE,
  input  logic [IMM_W-1:0]  D_I,
  input  logic [2:0]        D_S,
  input  logic [3:0]        D_ALU_OP,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              XM_WE,
  input  logic [RIDX_W-1:0] XM_IDX,
  input  logic [XLEN-1:0]   XM_RES,
  input  logic              MW_WE,
  input  logic [RIDX_W-1:0] MW_IDX,
  input  logic [XLEN-1:0]   MW_RES,
  output logic              E_VALID,
  output logic [XLEN-1:0]   E_RA,
  output logic [XLEN-1:0]   E_RB,
  output logic [RIDX_W-1:0] E_RA_IDX,
  output logic [RIDX_W-1:0] E_RB_IDX,
  output logic [RIDX_W-1:0] E_RT_IDX,
  output logic              E_RT_WE,
  output logic [IMM_W-1:0]  E_I,
  output logic [2:0]        E_S,
  output logic [3:0]        E_ALU_OP,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B
);

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_MW   = 2'b01;
  localparam logic [1:0] TAG_XM   = 2'b10;
  localparam logic [2:0] S_ZERO   = 3'b111;

  logic              r_valid;
  logic [XLEN-1:0]   r_ra;
  logic [XLEN-1:0]   r_rb;
  logic [RIDX_W-1:0] r_ra_idx;
  logic [RIDX_W-1:0] r_rb_idx;
  logic [RIDX_W-1:0] r_rt_idx;
  logic              r_rt_we;
  logic [IMM_W-1:0]  r_i;
  logic [2:0]        r_s;
  logic [3:0]        r_alu_op;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;

  logic [1:0]        w_ld_tag_a;
  logic [1:0]        w_ld_tag_b;
  logic [1:0]        w_hd_tag_a;
  logic [1:0]        w_hd_tag_b;
  logic [XLEN-1:0]   w_ld_ra;
  logic [XLEN-1:0]   w_ld_rb;
  logic [XLEN-1:0]   w_hd_ra;
  logic [XLEN-1:0]   w_hd_rb;

  // r0 never matches a producer, so a zero index always yields TAG_NONE.
  function automatic logic [1:0] fwd_tag(
    input logic [RIDX_W-1:0] idx,
    input logic              xm_we,
    input logic [RIDX_W-1:0] xm_idx,
    input logic              mw_we,
    input logic [RIDX_W-1:0] mw_idx
  );
    fwd_tag = TAG_NONE;
    if (idx != '0) begin
      if (xm_we && (xm_idx == idx))      fwd_tag = TAG_XM;
      else if (mw_we && (mw_idx == idx)) fwd_tag = TAG_MW;
    end
  endfunction

  assign w_ld_tag_a = fwd_tag(D_RA_IDX, XM_WE, XM_IDX, MW_WE, MW_IDX);
  assign w_ld_tag_b = fwd_tag(D_RB_IDX, XM_WE, XM_IDX, MW_WE, MW_IDX);
  assign w_hd_tag_a = fwd_tag(r_ra_idx, XM_WE, XM_IDX, MW_WE, MW_IDX);
  assign w_hd_tag_b = fwd_tag(r_rb_idx, XM_WE, XM_IDX, MW_WE, MW_IDX);

  assign w_ld_ra = (w_ld_tag_a == TAG_XM) ? XM_RES :
                   (w_ld_tag_a == TAG_MW) ? MW_RES :
                   (D_RA_IDX == '0)       ? '0     : D_RA;
  assign w_ld_rb = (w_ld_tag_b == TAG_XM) ? XM_RES :
                   (w_ld_tag_b == TAG_MW) ? MW_RES :
                   (D_RB_IDX == '0)       ? '0     : D_RB;

  // Held operands are only replaced when a producer for the held index completes.
  assign w_hd_ra = (w_hd_tag_a == TAG_XM) ? XM_RES :
                   (w_hd_tag_a == TAG_MW) ? MW_RES : r_ra;
  assign w_hd_rb = (w_hd_tag_b == TAG_XM) ? XM_RES :
                   (w_hd_tag_b == TAG_MW) ? MW_RES : r_rb;

  always_ff @(posedge clk) begin
    if (!reset_n || FLUSH) begin
      r_valid  <= 1'b0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_ra_idx <= '0;
      r_rb_idx <= '0;
      r_rt_idx <= '0;
      r_rt_we  <= 1'b0;
      r_i      <= '0;
      r_s      <= S_ZERO;
      r_alu_op <= '0;
      r_fwd_a  <= TAG_NONE;
      r_fwd_b  <= TAG_NONE;
    end else if (STALL) begin
      r_ra <= w_hd_ra;
      r_rb <= w_hd_rb;
      if (w_hd_tag_a != TAG_NONE) r_fwd_a <= w_hd_tag_a;
      if (w_hd_tag_b != TAG_NONE) r_fwd_b <= w_hd_tag_b;
    end else begin
      r_valid  <= D_VALID;
      r_ra     <= w_ld_ra;
      r_rb     <= w_ld_rb;
      r_ra_idx <= D_RA_IDX;
      r_rb_idx <= D_RB_IDX;
      r_rt_idx <= D_RT_IDX;
      r_rt_we  <= D_RT_WE & D_VALID;
      r_i      <= D_I;
      r_s      <= D_S;
      r_alu_op <= D_ALU_OP;
      r_fwd_a  <= w_ld_tag_a;
      r_fwd_b  <= w_ld_tag_b;
    end
  end

  assign E_VALID  = r_valid;
  assign E_RA     = r_ra;
  assign E_RB     = r_rb;
  assign E_RA_IDX = r_ra_idx;
  assign E_RB_IDX = r_rb_idx;
  assign E_RT_IDX = r_rt_idx;
  assign E_RT_WE  = r_rt_we;
  assign E_I      = r_i;
  assign E_S      = r_s;
  assign E_ALU_OP = r_alu_op;
  assign FWD_A    = r_fwd_a;
  assign FWD_B    = r_fwd_b;

endmodule

// File: tb/tb_id_ex_operand_register.sv
// Bench for id_ex_operand_register: directed scenarios plus randomized traffic against a stage model.
module tb_id_ex_operand_register;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        D_VALID, D_RT_WE, STALL, FLUSH, XM_WE, MW_WE;
  logic [31:0] D_RA, D_RB, XM_RES, MW_RES;
  logic [4:0]  D_RA_IDX, D_RB_IDX, D_RT_IDX, XM_IDX, MW_IDX;
  logic [20:0] D_I;
  logic [2:0]  D_S;
  logic [3:0]  D_ALU_OP;
  logic        E_VALID, E_RT_WE;
  logic [31:0] E_RA, E_RB;
  logic [4:0]  E_RA_IDX, E_RB_IDX, E_RT_IDX;
  logic [20:0] E_I;
  logic [2:0]  E_S;
  logic [3:0]  E_ALU_OP;
  logic [1:0]  FWD_A, FWD_B;

  int checks = 0;
  int passed = 0;

  // Expected stage contents.
  logic        m_valid, m_rt_we;
  logic [31:0] m_ra, m_rb;
  logic [4:0]  m_ra_idx, m_rb_idx, m_rt_idx;
  logic [20:0] m_i;
  logic [2:0]  m_s;
  logic [3:0]  m_op;
  logic [1:0]  m_fa, m_fb;

  always #5 clk = ~clk;

  id_ex_operand_register dut (
    .clk(clk), .reset_n(reset_n), .D_VALID(D_VALID), .D_RA(D_RA), .D_RB(D_RB),
    .D_RA_IDX(D_RA_IDX), .D_RB_IDX(D_RB_IDX), .D_RT_IDX(D_RT_IDX), .D_RT_WE(D_RT_WE),
    .D_I(D_I), .D_S(D_S), .D_ALU_OP(D_ALU_OP), .STALL(STALL), .FLUSH(FLUSH),
    .XM_WE(XM_WE), .XM_IDX(XM_IDX), .XM_RES(XM_RES), .MW_WE(MW_WE), .MW_IDX(MW_IDX),
    .MW_RES(MW_RES), .E_VALID(E_VALID), .E_RA(E_RA), .E_RB(E_RB), .E_RA_IDX(E_RA_IDX),
    .E_RB_IDX(E_RB_IDX), .E_RT_IDX(E_RT_IDX), .E_RT_WE(E_RT_WE), .E_I(E_I), .E_S(E_S),
    .E_ALU_OP(E_ALU_OP), .FWD_A(FWD_A), .FWD_B(FWD_B)
  );

  // Newest producer wins; r0 is hardwired zero and never forwarded.
  task automatic producer(input logic [4:0] idx, output logic hit,
                          output logic [31:0] val, output logic [1:0] tag);
    hit = 1'b0; val = 32'h0; tag = 2'd0;
    if (idx != 0 && XM_WE && XM_IDX == idx) begin
      hit = 1'b1; val = XM_RES; tag = 2'd2;
    end else if (idx != 0 && MW_WE && MW_IDX == idx) begin
      hit = 1'b1; val = MW_RES; tag = 2'd1;
    end
  endtask

  task automatic model_edge();
    logic        h;
    logic [31:0] v;
    logic [1:0]  t;
    if (!reset_n || FLUSH) begin
      {m_valid, m_rt_we, m_ra, m_rb, m_ra_idx, m_rb_idx, m_rt_idx, m_i, m_op, m_fa, m_fb} = '0;
      m_s = 3'b111;
    end else if (STALL) begin
      producer(m_ra_idx, h, v, t);
      if (h) begin m_ra = v; m_fa = t; end
      producer(m_rb_idx, h, v, t);
      if (h) begin m_rb = v; m_fb = t; end
    end else begin
      producer(D_RA_IDX, h, v, t);
      m_ra = h ? v : (D_RA_IDX == 0 ? 32'h0 : D_RA); m_fa = t;
      producer(D_RB_IDX, h, v, t);
      m_rb = h ? v : (D_RB_IDX == 0 ? 32'h0 : D_RB); m_fb = t;
      m_valid = D_VALID; m_rt_we = D_RT_WE && D_VALID;
      m_ra_idx = D_RA_IDX; m_rb_idx = D_RB_IDX; m_rt_idx = D_RT_IDX;
      m_i = D_I; m_s = D_S; m_op = D_ALU_OP;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset_n = 1'b1; D_VALID = 1'b0; D_RT_WE = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    XM_WE = 1'b0; MW_WE = 1'b0; D_RA = '0; D_RB = '0; XM_RES = '0; MW_RES = '0;
    D_RA_IDX = '0; D_RB_IDX = '0; D_RT_IDX = '0; XM_IDX = '0; MW_IDX = '0;
    D_I = '0; D_S = '0; D_ALU_OP = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    D_VALID = 1'b1; D_RT_WE = 1'b1; D_RA_IDX = 5'd4; D_RA = 32'h1234_5678; D_RT_IDX = 5'd9;
    D_S = 3'b010; D_ALU_OP = 4'h6; D_I = 21'h0ABCD;
    step();
    checks++; if (E_VALID !== 1'b1) $display("FAIL reset_pre_valid: got %b want 1", E_VALID); else passed++;
    reset_n = 1'b0; STALL = 1'b1; MW_WE = 1'b1; MW_IDX = 5'd4; MW_RES = 32'hFFFF_0000;
    step();
    checks++;
    if ({E_VALID, E_RA, E_RB, E_RA_IDX, E_RB_IDX, E_RT_IDX, E_RT_WE, E_I, E_ALU_OP} !== '0)
      $display("FAIL reset_zero: valid=%b ra=%h rb=%h rt=%0d we=%b i=%h op=%h", E_VALID, E_RA, E_RB, E_RT_IDX, E_RT_WE, E_I, E_ALU_OP);
    else passed++;
    checks++; if (E_S !== 3'b111) $display("FAIL reset_s: got %b want 111", E_S); else passed++;
    checks++; if ({FWD_A, FWD_B} !== 4'b0) $display("FAIL reset_fwd: got %b%b want 0000", FWD_A, FWD_B); else passed++;
    idle_inputs();
  endtask

  task automatic test_plain_load();
    idle_inputs();
    D_VALID = 1'b1; D_RB_IDX = 5'd9; D_RB = 32'h8431_FFEB; D_I = 21'h104761; D_S = 3'b101;
    XM_IDX = 5'd9; MW_IDX = 5'd9;
    step();
    checks++; if (E_RB !== 32'h8431_FFEB) $display("FAIL plain_rb: got %h want 8431ffeb", E_RB); else passed++;
    checks++; if (E_I !== 21'h104761) $display("FAIL plain_i: got %h want 104761", E_I); else passed++;
    checks++; if (E_S !== 3'b101) $display("FAIL plain_s: got %b want 101", E_S); else passed++;
    checks++; if (FWD_B !== 2'b00) $display("FAIL plain_fwd_b: got %b want 00", FWD_B); else passed++;
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    D_VALID = 1'b1; D_RB_IDX = 5'd7; D_RB = 32'h0BAD_0BAD;
    XM_WE = 1'b1; XM_IDX = 5'd7; XM_RES = 32'hAAAA_0001;
    MW_WE = 1'b1; MW_IDX = 5'd7; MW_RES = 32'h5555_0002;
    step();
    checks++; if (E_RB !== 32'hAAAA_0001) $display("FAIL prio_xm_rb: got %h want aaaa0001", E_RB); else passed++;
    checks++; if (FWD_B !== 2'b10) $display("FAIL prio_xm_tag: got %b want 10", FWD_B); else passed++;
    XM_WE = 1'b0;
    step();
    checks++; if (E_RB !== 32'h5555_0002) $display("FAIL prio_mw_rb: got %h want 55550002", E_RB); else passed++;
    checks++; if (FWD_B !== 2'b01) $display("FAIL prio_mw_tag: got %b want 01", FWD_B); else passed++;
  endtask

  task automatic test_r0_guard();
    idle_inputs();
    D_VALID = 1'b1; D_RA_IDX = 5'd0; D_RA = 32'hDEAD_BEEF;
    XM_WE = 1'b1; XM_IDX = 5'd0; XM_RES = 32'h1111_1111;
    MW_WE = 1'b1; MW_IDX = 5'd0; MW_RES = 32'h2222_2222;
    step();
    checks++; if (E_RA !== 32'h0) $display("FAIL r0_ra: got %h want 0", E_RA); else passed++;
    checks++; if (FWD_A !== 2'b00) $display("FAIL r0_tag: got %b want 00", FWD_A); else passed++;
  endtask

  task automatic test_stall_refresh();
    idle_inputs();
    D_VALID = 1'b1; D_RT_WE = 1'b1; D_RB_IDX = 5'd3; D_RB = 32'd5; D_RT_IDX = 5'd12;
    D_I = 21'h00777; D_S = 3'b011; D_ALU_OP = 4'h9;
    step();
    checks++; if (E_RB !== 32'd5) $display("FAIL stall_load_rb: got %h want 5", E_RB); else passed++;
    STALL = 1'b1; D_RB = 32'd99; D_I = 21'h1FFFF; D_S = 3'b000; D_RT_IDX = 5'd1; D_VALID = 1'b0;
    step();
    checks++; if (E_RB !== 32'd5) $display("FAIL stall_hold_rb: got %h want 5", E_RB); else passed++;
    MW_WE = 1'b1; MW_IDX = 5'd3; MW_RES = 32'h12;
    step();
    checks++; if (E_RB !== 32'h12) $display("FAIL stall_refresh_rb: got %h want 12", E_RB); else passed++;
    checks++; if (FWD_B !== 2'b01) $display("FAIL stall_refresh_tag: got %b want 01", FWD_B); else passed++;
    checks++;
    if ({E_VALID, E_RT_WE, E_RT_IDX, E_RB_IDX, E_I, E_S, E_ALU_OP} !== {1'b1, 1'b1, 5'd12, 5'd3, 21'h00777, 3'b011, 4'h9})
      $display("FAIL stall_fields: got v=%b we=%b rt=%0d rbi=%0d i=%h s=%b op=%h want 1 1 12 3 00777 011 9",
               E_VALID, E_RT_WE, E_RT_IDX, E_RB_IDX, E_I, E_S, E_ALU_OP);
    else passed++;
    MW_WE = 1'b0;
    step();
    checks++; if (FWD_B !== 2'b01) $display("FAIL stall_tag_held: got %b want 01", FWD_B); else passed++;
  endtask

  task automatic test_flush_stall();
    idle_inputs();
    D_VALID = 1'b1; D_RT_WE = 1'b1; D_RT_IDX = 5'd6; D_RB_IDX = 5'd2; D_RB = 32'hCAFE; D_S = 3'b001;
    step();
    FLUSH = 1'b1; STALL = 1'b1;
    step();
    checks++; if (E_VALID !== 1'b0) $display("FAIL flush_valid: got %b want 0", E_VALID); else passed++;
    checks++; if (E_RT_WE !== 1'b0) $display("FAIL flush_rt_we: got %b want 0", E_RT_WE); else passed++;
    checks++; if (E_S !== 3'b111) $display("FAIL flush_s: got %b want 111", E_S); else passed++;
    checks++; if ({E_RB, FWD_B} !== '0) $display("FAIL flush_rb: got %h/%b want 0/00", E_RB, FWD_B); else passed++;
    FLUSH = 1'b0; STALL = 1'b0; D_RB = 32'hBEEF_0042; D_S = 3'b100;
    step();
    checks++;
    if ({E_VALID, E_RT_WE, E_RB, E_S} !== {1'b1, 1'b1, 32'hBEEF_0042, 3'b100})
      $display("FAIL flush_reload: got v=%b we=%b rb=%h s=%b want 1 1 beef0042 100", E_VALID, E_RT_WE, E_RB, E_S);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      FLUSH = ($urandom_range(0, 9) == 0);
      STALL = ($urandom_range(0, 3) == 0);
      D_VALID = $urandom_range(0, 1); D_RT_WE = $urandom_range(0, 1);
      D_RA = $urandom; D_RB = $urandom; XM_RES = $urandom; MW_RES = $urandom;
      D_RA_IDX = $urandom_range(0, 3); D_RB_IDX = $urandom_range(0, 3);
      D_RT_IDX = $urandom; XM_IDX = $urandom_range(0, 3); MW_IDX = $urandom_range(0, 3);
      XM_WE = $urandom_range(0, 1); MW_WE = $urandom_range(0, 1);
      D_I = $urandom; D_S = $urandom; D_ALU_OP = $urandom;
      step();
      checks++;
      if ({E_VALID, E_RT_WE, E_RA, E_RB, E_RA_IDX, E_RB_IDX, E_RT_IDX, E_I, E_S, E_ALU_OP, FWD_A, FWD_B} !==
          {m_valid, m_rt_we, m_ra, m_rb, m_ra_idx, m_rb_idx, m_rt_idx, m_i, m_s, m_op, m_fa, m_fb}) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got v=%b we=%b ra=%h rb=%h i=%h s=%b op=%h fa=%b fb=%b want v=%b we=%b ra=%h rb=%h i=%h s=%b op=%h fa=%b fb=%b",
                   n, E_VALID, E_RT_WE, E_RA, E_RB, E_I, E_S, E_ALU_OP, FWD_A, FWD_B,
                   m_valid, m_rt_we, m_ra, m_rb, m_i, m_s, m_op, m_fa, m_fb);
        errs++;
      end else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    test_reset();
    test_plain_load();
    test_forward_priority();
    test_r0_guard();
    test_stall_refresh();
    test_flush_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
